// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding and index width for the PE sequencer
package pe_pkg;

    localparam int REG_SIZE_DEF = 4;
    localparam int IDX_W        = REG_SIZE_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIN,
        CAPT,
        HOLD
    } state_t;

endpackage

// File: rtl/pe_seq_result.sv
// rtl/pe_seq_result.sv - result differencing against the never-cleared PE accumulator
module pe_seq_result
    import pe_pkg::*;
#(
    parameter int PRECISION = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capt,
    input  logic [PRECISION-1:0] pe_out,
    input  logic                 r_ready,
    output logic                 r_valid,
    output logic [PRECISION-1:0] r_data
);

    logic [PRECISION-1:0] base;

    // Modulo subtraction stays exact even when the PE accumulator wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (capt) begin
            r_data  <= pe_out - base;
            base    <= pe_out;
            r_valid <= 1'b1;
        end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_seq.sv
// rtl/pe_seq.sv - weight/activation sequencer for one MAC PE; PE_SEQ_STATS_EN adds vec_cnt/stall_cnt
module pe_seq
    import pe_pkg::*;
#(
    parameter int PRECISION = 16,
    parameter int REG_SIZE  = IDX_W,
    parameter int NUM_WGT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [PRECISION-1:0] w_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [PRECISION-1:0] a_data,
    output logic [PRECISION-1:0] pe_act,
    output logic [PRECISION-1:0] pe_wgt,
    output logic                 pe_store,
    output logic                 pe_reuse,
    output logic [REG_SIZE-1:0]  pe_addr,
    output logic                 pe_finish,
    input  logic [PRECISION-1:0] pe_out,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [PRECISION-1:0] r_data
`ifdef PE_SEQ_STATS_EN
    ,
    output logic [31:0]          vec_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [REG_SIZE-1:0] ONE  = REG_SIZE'(1);
    localparam logic [REG_SIZE-1:0] LAST = REG_SIZE'(NUM_WGT);

    state_t              state;
    logic [REG_SIZE-1:0] idx;
    logic                armed;

    // armed keeps w_ready low while reset is held and for the first cycle after.
    assign w_ready   = armed && (state == IDLE || state == LOAD);
    assign pe_store  = w_ready && w_valid;
    assign pe_wgt    = pe_store ? w_data : '0;
    assign a_ready   = (state == RUN);
    assign pe_reuse  = (state == RUN);
    assign pe_act    = (state == RUN && a_valid) ? a_data : '0;
    assign pe_addr   = (pe_store || state == RUN) ? idx : '0;
    assign pe_finish = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= ONE;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE, LOAD: begin
                    if (pe_store) begin
                        if (idx == LAST) begin
                            state <= RUN;
                            idx   <= ONE;
                        end else begin
                            state <= LOAD;
                            idx   <= idx + ONE;
                        end
                    end
                end
                RUN: begin
                    if (a_valid) begin
                        if (idx == LAST) begin
                            state <= FIN;
                            idx   <= ONE;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                FIN:  state <= CAPT;
                CAPT: state <= HOLD;
                HOLD: begin
                    if (r_ready) begin
                        state <= w_valid ? LOAD : RUN;
                        idx   <= ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pe_seq_result #(
        .PRECISION(PRECISION)
    ) u_result (
        .clk    (clk),
        .rst_n  (rst_n),
        .capt   (state == CAPT),
        .pe_out (pe_out),
        .r_ready(r_ready),
        .r_valid(r_valid),
        .r_data (r_data)
    );

`ifdef PE_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (r_valid && r_ready)
                vec_cnt <= vec_cnt + 32'd1;
            if (state == RUN && !a_valid)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_seq.sv
// tb/tb_pe_seq.sv - directed bench for pe_seq tied to a behavioural MAC PE
module tb_pe_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_valid = 1'b0, a_valid = 1'b0, r_ready = 1'b0;
    logic [15:0] w_data = '0, a_data = '0;
    logic        w_ready, a_ready, pe_store, pe_reuse, pe_finish, r_valid;
    logic [15:0] pe_act, pe_wgt, pe_out, r_data;
    logic [3:0]  pe_addr;
`ifdef PE_SEQ_STATS_EN
    logic [31:0] vec_cnt, stall_cnt;
    logic [31:0] stall_snap;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_k = 0;
    logic        last_store, last_wr;
    logic [3:0]  last_addr;
    logic [15:0] last_wgt, last_act;

    pe_seq dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .pe_act(pe_act), .pe_wgt(pe_wgt), .pe_store(pe_store), .pe_reuse(pe_reuse),
        .pe_addr(pe_addr), .pe_finish(pe_finish), .pe_out(pe_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
`ifdef PE_SEQ_STATS_EN
        , .vec_cnt(vec_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // Behavioural PE: register file, accumulator that is never cleared, output latch on finish.
    logic [15:0] rf [0:3];
    logic [15:0] acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            acc    <= '0;
            pe_out <= '0;
        end else begin
            if (pe_store) rf[pe_addr[1:0]] <= pe_wgt;
            if (pe_reuse) acc <= acc + pe_act * rf[pe_addr[1:0]];
            if (pe_finish) pe_out <= acc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed no event expected one within 40 cycles", tag);
    endtask

    task automatic send_w(input logic [15:0] d);
        int n;
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = d;
        #1;
        n = 0;
        while (!w_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!w_ready) timeout("w_handshake");
        last_store = pe_store;
        last_addr  = pe_addr;
        last_wgt   = pe_wgt;
        @(posedge clk); #1;
    endtask

    task automatic send_a(input logic [15:0] d);
        int n;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = d;
        #1;
        n = 0;
        while (!a_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!a_ready) timeout("a_handshake");
        last_act  = pe_act;
        last_addr = pe_addr;
        last_wr   = w_ready;
        last_k    = cyc;
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_data  = 16'h5A5A;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp, input bit lat);
        int n;
        @(negedge clk); #1;
        n = 0;
        while (!r_valid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!r_valid) timeout({tag, "_rvalid"});
        else begin
            chk(tag, r_data, exp);
            if (lat) chk({tag, "_latency"}, cyc, last_k + 3);
        end
    endtask

    task automatic release_r();
        @(negedge clk);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        send_w(a);
        send_w(b);
        send_w(c);
        w_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_w_ready", w_ready, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_pe_addr", pe_addr, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_data", r_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: weights 2,3,4 then acts 1,1,1 -> 9
        send_w(16'd2);
        chk("s1_first_store", last_store, 1);
        chk("s1_first_addr", last_addr, 1);
        chk("s1_first_wgt", last_wgt, 2);
        send_w(16'd3);
        send_w(16'd4);
        chk("s1_third_addr", last_addr, 3);
        w_valid = 1'b0;
        chk("s1_rf1", rf[1], 2);
        chk("s1_rf2", rf[2], 3);
        chk("s1_rf3", rf[3], 4);
        send_a(16'd1);
        chk("s1_act", last_act, 1);
        chk("s1_run_w_ready", last_wr, 0);
        send_a(16'd1);
        chk("s1_addr2", last_addr, 2);
        send_a(16'd1);
        wait_result("s1_result", 16'd9, 1);
        chk("s1_hold_a_ready", a_ready, 0);
        release_r();

        // 2: second vector without reload -> 14
        send_a(16'd5);
        send_a(16'd0);
        send_a(16'd1);
        wait_result("s2_result", 16'd14, 1);
        chk("s2_pe_out", pe_out, 23);
        release_r();

        // 3: four stalled cycles mid-vector add nothing
`ifdef PE_SEQ_STATS_EN
        stall_snap = stall_cnt;
`endif
        send_a(16'd5);
        a_data = 16'h1234;
        repeat (4) @(posedge clk);
        #1;
        chk("s3_stall_act", pe_act, 0);
        send_a(16'd0);
        send_a(16'd1);
        wait_result("s3_result", 16'd14, 1);
`ifdef PE_SEQ_STATS_EN
        chk("s3_stall_cnt", stall_cnt - stall_snap, 4);
`endif

        // 4: hold r_ready low with w_valid high, then reload 1,1,1 and acts 7,8,9 -> 24
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = 16'd1;
        repeat (5) begin
            @(negedge clk); #1;
            chk("s4_hold_data", r_data, 14);
            chk("s4_hold_w_ready", w_ready, 0);
        end
        release_r();
        load3(16'd1, 16'd1, 16'd1);
        chk("s4_rf1", rf[1], 1);
        chk("s4_rf3", rf[3], 1);
        send_a(16'd7);
        send_a(16'd8);
        send_a(16'd9);
        wait_result("s4_result", 16'd24, 1);

        // 5: modulo wrap
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = 16'hFFFF;
        release_r();
        load3(16'hFFFF, 16'hFFFF, 16'hFFFF);
        send_a(16'hFFFF);
        send_a(16'hFFFF);
        send_a(16'hFFFF);
        wait_result("s5_wrap", 16'h0003, 1);
        release_r();
        send_a(16'd1);
        send_a(16'd1);
        send_a(16'd1);
        wait_result("s5_wrap2", 16'hFFFD, 1);
`ifdef PE_SEQ_STATS_EN
        chk("s5_vec_cnt", vec_cnt, 5);
`endif
        release_r();

        // 6: async reset during RUN, then rerun scenario 1
        send_a(16'd3);
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 16'd2;
        rst_n   = 1'b0;
        #1;
        chk("s6_a_ready", a_ready, 0);
        chk("s6_pe_act", pe_act, 0);
        chk("s6_pe_reuse", pe_reuse, 0);
        chk("s6_r_valid", r_valid, 0);
        chk("s6_r_data", r_data, 0);
        chk("s6_w_ready", w_ready, 0);
        chk("s6_pe_out", pe_out, 0);
`ifdef PE_SEQ_STATS_EN
        chk("s6_vec_cnt", vec_cnt, 0);
        chk("s6_stall_cnt", stall_cnt, 0);
`endif
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load3(16'd2, 16'd3, 16'd4);
        send_a(16'd1);
        send_a(16'd1);
        send_a(16'd1);
        wait_result("s6_rerun", 16'd9, 1);
        release_r();
        @(negedge clk); #1;
        chk("s6_r_valid_drop", r_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected $finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
